// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// Shared widths, constants and the receiver state encoding.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic [I2C_ADDR_W-1:0] I2C_GENERAL_CALL = 7'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_rx_state_e;
endpackage

// File: rtl/i2c_line_sync.sv
`timescale 1ns/1ps
// Synchronizer for one I2C bus line with rise/fall detection.
// Flops reset to 1 so an idle (pulled-up) bus gives no spurious edges.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the async line through the synchronizer, then one history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;
endmodule

// File: rtl/i2c_slave_rx.sv
`timescale 1ns/1ps
// Write-only I2C slave receiver: START/STOP detection, address match,
// ACK generation on an open-drain sda, and parallel byte output.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [I2C_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  addr_match,
  output logic                  busy,
  output logic                  start_det,
  output logic                  stop_det,
  output logic [7:0]            byte_count
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .line_i(scl),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .line_i(sda),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  // sda edges while scl is high are bus conditions, not data.
  logic start_ev, stop_ev;
  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  i2c_rx_state_e         state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_DATA_W-1:0] shift_q, shift_d;
  logic [I2C_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  addr_match_q, addr_match_d;
  logic                  start_det_q, start_det_d;
  logic                  stop_det_q, stop_det_d;
  logic [7:0]            byte_count_q, byte_count_d;
  logic                  sda_oe_q, sda_oe_d;

  // Byte as it stands once the current rising-edge bit is shifted in.
  logic [I2C_DATA_W-1:0] byte_w;
  assign byte_w = {shift_q[I2C_DATA_W-2:0], sda_lvl};

  // Next-state logic: STOP beats START beats bit processing.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    addr_match_d = addr_match_q;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;
    byte_count_d = byte_count_q;
    sda_oe_d     = sda_oe_q;

    if (stop_ev) begin
      state_d      = IDLE;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      stop_det_d   = 1'b1;
    end else if (start_ev) begin
      state_d      = ADDR;
      bit_cnt_d    = 4'd0;
      shift_d      = '0;
      byte_count_d = 8'd0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      start_det_d  = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_w;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (byte_w[7:1] == SLAVE_ADDR && !byte_w[0] &&
                  byte_w[7:1] != I2C_GENERAL_CALL)
                state_d = ADDR_ACK;
              else
                state_d = IGNORE;
            end
          end
        end
        // First falling edge starts the ACK drive, the next one ends it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = DATA;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_d   = byte_w;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) state_d = DATA_ACK;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d     = 1'b1;
              rx_valid_d   = 1'b1;
              rx_data_d    = shift_q;
              byte_count_d = (byte_count_q == 8'hFF) ? 8'hFF : byte_count_q + 8'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      byte_count_q <= 8'd0;
      sda_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
      byte_count_q <= byte_count_d;
      sda_oe_q     <= sda_oe_d;
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign busy       = (state_q != IDLE);
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign byte_count = byte_count_q;
endmodule

// File: tb/tb_i2c_slave_rx.sv
`timescale 1ns/1ps
// Randomized bench for i2c_slave_rx: a bit-banged master drives the bus,
// expected bytes go into a scoreboard queue, a monitor pops on rx_valid.
module tb_i2c_slave_rx;
  localparam logic [6:0] OWN = 7'h50;
  localparam int Q = 4;  // quarter bit period in clk cycles

  logic clk = 1'b0;
  logic rst;
  logic scl_r, sda_m;
  wire  sda;
  logic [7:0] rx_data, byte_count;
  logic rx_valid, addr_match, busy, start_det, stop_det;

  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl_r), .sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .addr_match(addr_match),
    .busy(busy), .start_det(start_det), .stop_det(stop_det),
    .byte_count(byte_count)
  );

  typedef struct { logic [7:0] d; logic [7:0] c; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] dq[$];
  int checks = 0, failures = 0;
  int st_cnt = 0, sp_cnt = 0, exp_st = 0, exp_sp = 0;
  bit am_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: counts bus-condition pulses and scores every rx_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (start_det) st_cnt++;
      if (stop_det) sp_cnt++;
      if (addr_match) am_seen = 1;
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected actual=%0h expected=none at %0t", rx_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e.d);
          chk("byte_count", byte_count, e.c);
        end
      end
    end
  end

  task automatic start_cond();
    if (!scl_r) begin
      sda_m = 1; tick(Q); scl_r = 1; tick(Q);
    end
    sda_m = 0; tick(Q);
    scl_r = 0; tick(Q);
    exp_st++;
  endtask

  task automatic stop_cond();
    sda_m = 0; tick(Q);
    scl_r = 1; tick(Q);
    sda_m = 1; tick(2*Q);
    exp_sp++;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(Q);
    scl_r = 1; tick(Q);
    chk("bus_bit", sda, b);
    tick(Q);
    scl_r = 0; tick(Q);
  endtask

  task automatic ack_bit(output logic a);
    sda_m = 1; tick(Q);
    scl_r = 1; tick(Q);
    a = sda;
    tick(Q);
    scl_r = 0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // One transaction with the bytes in dq; optional partial byte and STOP.
  task automatic xfer(input logic [6:0] a, input logic rw, input int part_bits,
                      input logic [7:0] part, input bit do_stop);
    logic ab;
    bit   acked;
    int   cnt;
    exp_t e;
    acked = (a == OWN) && !rw && (a != 7'h00);
    start_cond();
    am_seen = 0;
    chk("count_clr", byte_count, 0);
    send_byte({a, rw});
    ack_bit(ab);
    chk("addr_ack", ab, acked ? 0 : 1);
    cnt = 0;
    foreach (dq[i]) begin
      if (acked) begin
        cnt = cnt + 1;
        e.d = dq[i];
        e.c = (cnt > 255) ? 8'd255 : 8'(cnt);
        exp_q.push_back(e);
      end
      send_byte(dq[i]);
      ack_bit(ab);
      chk("data_ack", ab, acked ? 0 : 1);
    end
    for (int i = 0; i < part_bits; i++) send_bit(part[7-i]);
    chk("busy_in_xfer", busy, 1);
    chk("addr_match_seen", am_seen, acked);
    if (do_stop) begin
      stop_cond();
      tick(4);
      chk("busy_idle", busy, 0);
      chk("addr_match_clr", addr_match, 0);
      chk("start_count", st_cnt, exp_st);
      chk("stop_count", sp_cnt, exp_sp);
      chk("rxq_drained", exp_q.size(), 0);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_sda"}, sda, 1);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_byte_count"}, byte_count, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_addr_match"}, addr_match, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start_det"}, start_det, 0);
    chk({tag, "_stop_det"}, stop_det, 0);
  endtask

  // Reset while the data ACK is on the bus; later traffic must be ignored.
  task automatic reset_mid_ack();
    logic ab;
    logic [7:0] d;
    exp_t e;
    d = 8'($urandom);
    start_cond();
    send_byte({OWN, 1'b0});
    ack_bit(ab);
    chk("rst_addr_ack", ab, 0);
    e.d = d; e.c = 8'd1;
    exp_q.push_back(e);
    send_byte(d);
    sda_m = 1; tick(Q);
    chk("ack_before_rst", sda, 0);
    rst = 1; tick(1);
    reset_checks("midack");
    tick(1); rst = 0;
    am_seen = 0;
    scl_r = 1; tick(2*Q);
    scl_r = 0; tick(Q);
    send_byte(8'($urandom));
    ack_bit(ab);
    chk("post_rst_nack", ab, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_am", am_seen, 0);
    chk("post_rst_start_count", st_cnt, exp_st);
    stop_cond();
    tick(4);
    chk("post_rst_stop_count", sp_cnt, exp_sp);
    chk("rst_rxq_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1; scl_r = 1; sda_m = 1;
    tick(4);
    reset_checks("reset");
    rst = 0;
    tick(4);

    dq.delete(); dq.push_back(8'hA5);
    xfer(OWN, 1'b0, 0, 8'h00, 1);
    dq.delete(); dq.push_back(8'h3C);
    xfer(7'h51, 1'b0, 0, 8'h00, 1);
    dq.delete();
    xfer(OWN, 1'b1, 0, 8'h00, 1);
    dq.delete(); dq.push_back(8'h00);
    xfer(7'h00, 1'b0, 0, 8'h00, 1);
    dq.delete(); dq.push_back(8'h01); dq.push_back(8'h02); dq.push_back(8'h03);
    xfer(OWN, 1'b0, 0, 8'h00, 1);

    dq.delete();
    xfer(OWN, 1'b0, 4, 8'hF0, 0);
    dq.delete(); dq.push_back(8'h11);
    xfer(OWN, 1'b0, 0, 8'h00, 1);

    for (int t = 0; t < 10; t++) begin
      logic [6:0] a;
      logic       rw;
      a  = ($urandom_range(0, 1) == 1) ? OWN : 7'($urandom);
      rw = ($urandom_range(0, 3) == 0);
      dq.delete();
      for (int k = $urandom_range(0, 4); k > 0; k--) dq.push_back(8'($urandom));
      xfer(a, rw, 0, 8'h00, 1);
    end

    dq.delete();
    for (int k = 0; k < 257; k++) dq.push_back(8'($urandom));
    xfer(OWN, 1'b0, 0, 8'h00, 1);

    reset_mid_ack();

    dq.delete(); dq.push_back(8'h5A);
    xfer(OWN, 1'b0, 0, 8'h00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
